clock_period_meter: RTL

- Measures an incoming slow clock or periodic signal in units of the system clock: the inverse of the divider, which makes a slow clock from a count.
- Synchronises the asynchronous input, detects its edges, and counts CLK cycles between rising edges and from rise to fall.
- Reports registered PERIOD and HIGH_TIME with a one-cycle VALID strobe, plus a TIMEOUT flag when the input stalls.
- Used to check divided clocks and external tick sources against CLK.

---
 rtl/clock_period_meter.sv | 115 +++++++++++
 1 files changed

// File: rtl/clock_period_meter.sv
// -----------------------------------------------------------------------------
// clock_period_meter
//
// Measures a slow clock or periodic tick in units of CLK. SIG is synchronised
// through two flops, edge-detected, and a cycle counter measures the spacing
// between rising edges (PERIOD) and from rise to fall (HIGH_TIME).
//
// Ports:
//   CLK        system clock; all state updates on its rising edge
//   RST_N      asynchronous active-low reset
//   EN         synchronous measurement enable
//   SIG        signal under measurement (asynchronous to CLK)
//   PERIOD     CLK cycles between the last two rising edges of SIG
//   HIGH_TIME  CLK cycles from rise to fall within that period
//   VALID      one-cycle pulse: PERIOD/HIGH_TIME updated this cycle
//   TIMEOUT    level: no rising edge seen within 2^WIDTH-1 cycles
// -----------------------------------------------------------------------------
module clock_period_meter #(
  parameter int WIDTH = 16
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             EN,
  input  logic             SIG,
  output logic [WIDTH-1:0] PERIOD,
  output logic [WIDTH-1:0] HIGH_TIME,
  output logic             VALID,
  output logic             TIMEOUT
);

  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_MEASURE = 1'b1;

  localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [1:0]       sync_reg;
  logic             sig_d_reg;
  logic [0:0]       state_reg;
  logic [WIDTH-1:0] cnt_reg;
  logic [WIDTH-1:0] hi_lat_reg;
  logic [WIDTH-1:0] period_reg;
  logic [WIDTH-1:0] high_time_reg;
  logic             valid_reg;
  logic             timeout_reg;

  logic sig_s;
  logic rise;
  logic fall;

  assign sig_s = sync_reg[1];
  assign rise  = sig_s & ~sig_d_reg;
  assign fall  = ~sig_s & sig_d_reg;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync_reg      <= 2'b00;
      sig_d_reg     <= 1'b0;
      state_reg     <= ST_IDLE;
      cnt_reg       <= '0;
      hi_lat_reg    <= '0;
      period_reg    <= '0;
      high_time_reg <= '0;
      valid_reg     <= 1'b0;
      timeout_reg   <= 1'b0;
    end else begin
      // The synchroniser keeps running while disabled so that re-enabling
      // never sees a stale edge from before the disable.
      sync_reg  <= {sync_reg[0], SIG};
      sig_d_reg <= sig_s;
      valid_reg <= 1'b0;

      if (!EN) begin
        state_reg  <= ST_IDLE;
        cnt_reg    <= '0;
        hi_lat_reg <= '0;
      end else begin
        case (state_reg)
          ST_IDLE: begin
            // First rise only starts the count; there is no full period yet.
            if (rise) begin
              cnt_reg   <= CNT_ONE;
              state_reg <= ST_MEASURE;
            end
          end
          default: begin
            if (rise) begin
              // A rise on the saturation cycle still counts as a valid period.
              period_reg    <= cnt_reg;
              high_time_reg <= hi_lat_reg;
              valid_reg     <= 1'b1;
              timeout_reg   <= 1'b0;
              cnt_reg       <= CNT_ONE;
            end else if (cnt_reg == CNT_MAX) begin
              state_reg   <= ST_IDLE;
              timeout_reg <= 1'b1;
              cnt_reg     <= '0;
            end else begin
              if (fall) begin
                hi_lat_reg <= cnt_reg;
              end
              cnt_reg <= cnt_reg + CNT_ONE;
            end
          end
        endcase
      end
    end
  end

  assign PERIOD    = period_reg;
  assign HIGH_TIME = high_time_reg;
  assign VALID     = valid_reg;
  assign TIMEOUT   = timeout_reg;

endmodule
